// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage: frame accept, single/iterative ops, result handshake, LEDs
module alu_exec_stage #(
    parameter int WIDTH     = 4,
    parameter int LED_WIDTH = 4
) (
    input  logic                   clk_arduino,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       operando_1,
    input  logic [WIDTH-1:0]       operando_2,
    input  logic [3:0]             operador,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     resultado,
    output logic [3:0]             flags,
    output logic                   error,
    output logic                   busy,
    output logic [LED_WIDTH-1:0]   leds
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, rem_q, rem_d;
    logic [3:0]             op_q, op_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d, mcand_q, mcand_d, res_q, res_d;
    logic [3:0]             flags_q, flags_d;
    logic                   err_q, err_d, valid_q, valid_d;
    logic [LED_WIDTH-1:0]   leds_q, leds_d;

    logic [WIDTH:0]         sum_w, diff_w, shl_w, shr_w, rem_sh;
    int unsigned            shamt;
    logic [WIDTH-1:0]       narrow_res, rem_step, quot_step;
    logic                   narrow_c, narrow_v, q_bit, iterative, last_step, illegal;
    logic [2*WIDTH-1:0]     prod_step, mc_res;

    // Single-cycle results plus one shift-add / restoring-divide step from the held operands
    always_comb begin
        sum_w      = {1'b0, a_q} + {1'b0, b_q};
        diff_w     = {1'b0, a_q} - {1'b0, b_q};
        shamt      = 32'(b_q) % 32'(WIDTH);
        // One guard bit on each side catches the last bit shifted out
        shl_w      = {1'b0, a_q} << shamt;
        shr_w      = {a_q, 1'b0} >> shamt;
        narrow_res = '0;
        narrow_c   = 1'b0;
        narrow_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                narrow_res = sum_w[WIDTH-1:0];
                narrow_c   = sum_w[WIDTH];
                narrow_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                narrow_res = diff_w[WIDTH-1:0];
                narrow_c   = diff_w[WIDTH];
                narrow_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: narrow_res = a_q & b_q;
            OP_OR:  narrow_res = a_q | b_q;
            OP_XOR: narrow_res = a_q ^ b_q;
            OP_SHL: begin
                narrow_res = shl_w[WIDTH-1:0];
                narrow_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                narrow_res = shr_w[WIDTH:1];
                narrow_c   = shr_w[0];
            end
            default: ;
        endcase

        prod_step = prod_q + (b_q[0] ? mcand_q : '0);
        rem_sh    = {rem_q, a_q[WIDTH-1]};
        q_bit     = (rem_sh >= {1'b0, b_q});
        rem_step  = q_bit ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
        quot_step = {a_q[WIDTH-2:0], q_bit};
        mc_res    = (op_q == OP_MUL) ? prod_step : {rem_step, quot_step};

        illegal   = (op_q > OP_DIV);
        iterative = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state and register updates for IDLE/CALC/DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = err_q;
        valid_d = valid_q;
        leds_d  = leds_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = operando_1;
                    b_d     = operando_2;
                    op_d    = operador;
                    cnt_d   = '0;
                    prod_d  = '0;
                    mcand_d = {{WIDTH{1'b0}}, operando_1};
                    rem_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (iterative) begin
                    if (op_q == OP_MUL) begin
                        prod_d  = prod_step;
                        mcand_d = mcand_q << 1;
                        b_d     = b_q >> 1;
                    end else begin
                        a_d   = quot_step;
                        rem_d = rem_step;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (last_step) begin
                        res_d   = mc_res;
                        flags_d = {(mc_res == '0), 3'b000};
                        err_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    valid_d = 1'b1;
                    state_d = DONE;
                    if (illegal) begin
                        res_d   = '0;
                        flags_d = 4'b1000;
                        err_d   = 1'b1;
                    end else if (op_q == OP_DIV) begin
                        // Divide by zero: only a zero divisor reaches here for DIV
                        res_d   = '1;
                        flags_d = 4'b0000;
                        err_d   = 1'b1;
                    end else begin
                        res_d   = {{WIDTH{1'b0}}, narrow_res};
                        flags_d = {(narrow_res == '0), narrow_res[WIDTH-1], narrow_c, narrow_v};
                        err_d   = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    leds_d  = res_q[LED_WIDTH-1:0];
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts anything in flight
    always_ff @(posedge clk_arduino) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            leds_q  <= leds_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = valid_q;
    assign resultado = res_q;
    assign flags     = flags_q;
    assign error     = err_q;
    assign leds      = leds_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed vector bench for alu_exec_stage
module tb_alu_exec_stage;
    localparam int WIDTH     = 4;
    localparam int LED_WIDTH = 4;
    localparam int NV        = 16;

    logic                 clk_arduino = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     operando_1;
    logic [WIDTH-1:0]     operando_2;
    logic [3:0]           operador;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   resultado;
    logic [3:0]           flags;
    logic                 error;
    logic                 busy;
    logic [LED_WIDTH-1:0] leds;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic [3:0] fl;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs [NV];

    alu_exec_stage #(.WIDTH(WIDTH), .LED_WIDTH(LED_WIDTH)) dut (
        .clk_arduino (clk_arduino),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .operando_1  (operando_1),
        .operando_2  (operando_2),
        .operador    (operador),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .resultado   (resultado),
        .flags       (flags),
        .error       (error),
        .busy        (busy),
        .leds        (leds)
    );

    always #5 clk_arduino = ~clk_arduino;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Present a frame for one accept edge, then count edges until out_valid (bounded)
    task automatic do_frame(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, output int lat);
        @(negedge clk_arduino);
        in_valid   = 1'b1;
        operador   = op;
        operando_1 = a;
        operando_2 = b;
        @(posedge clk_arduino);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk_arduino);
            #1 lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk_arduino);
        out_ready = 1'b1;
        @(posedge clk_arduino);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        //            op     a      b      res    flags(ZNCV) err  lat
        vecs[0]  = '{4'd0, 4'd9,  4'd8,  8'h01, 4'b0011, 1'b0, 1};
        vecs[1]  = '{4'd7, 4'd15, 4'd15, 8'hE1, 4'b0000, 1'b0, 4};
        vecs[2]  = '{4'd8, 4'd13, 4'd4,  8'h13, 4'b0000, 1'b0, 4};
        vecs[3]  = '{4'd8, 4'd7,  4'd0,  8'hFF, 4'b0000, 1'b1, 1};
        vecs[4]  = '{4'hF, 4'd3,  4'd2,  8'h00, 4'b1000, 1'b1, 1};
        vecs[5]  = '{4'd3, 4'd5,  4'd10, 8'h0F, 4'b0100, 1'b0, 1};
        vecs[6]  = '{4'd1, 4'd3,  4'd5,  8'h0E, 4'b0110, 1'b0, 1};
        vecs[7]  = '{4'd2, 4'd12, 4'd3,  8'h00, 4'b1000, 1'b0, 1};
        vecs[8]  = '{4'd4, 4'd6,  4'd5,  8'h03, 4'b0000, 1'b0, 1};
        vecs[9]  = '{4'd5, 4'hB,  4'd6,  8'h0C, 4'b0100, 1'b0, 1};
        vecs[10] = '{4'd6, 4'hB,  4'd1,  8'h05, 4'b0010, 1'b0, 1};
        vecs[11] = '{4'd1, 4'd8,  4'd1,  8'h07, 4'b0001, 1'b0, 1};
        vecs[12] = '{4'd0, 4'd0,  4'd0,  8'h00, 4'b1000, 1'b0, 1};
        vecs[13] = '{4'd7, 4'd0,  4'd5,  8'h00, 4'b1000, 1'b0, 4};
        vecs[14] = '{4'd5, 4'd1,  4'd4,  8'h01, 4'b0000, 1'b0, 1};
        vecs[15] = '{4'd8, 4'd15, 4'd1,  8'h0F, 4'b0000, 1'b0, 4};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        operando_1 = '0; operando_2 = '0; operador = '0;
        repeat (3) @(posedge clk_arduino);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_resultado", 32'(resultado), 32'd0);
        chk("rst_flags",     32'(flags),     32'd0);
        chk("rst_error",     32'(error),     32'd0);
        chk("rst_leds",      32'(leds),      32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            chk($sformatf("in_ready_pre[%0d]", i), 32'(in_ready), 32'd1);
            do_frame(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("latency[%0d]", i),   32'(lat),       32'(vecs[i].lat));
            chk($sformatf("resultado[%0d]", i), 32'(resultado), 32'(vecs[i].res));
            chk($sformatf("flags[%0d]", i),     32'(flags),     32'(vecs[i].fl));
            chk($sformatf("error[%0d]", i),     32'(error),     32'(vecs[i].err));
            consume();
            chk($sformatf("leds[%0d]", i),      32'(leds),      32'(vecs[i].res[3:0]));
            chk($sformatf("in_ready_post[%0d]", i), 32'(in_ready), 32'd1);
            chk($sformatf("out_valid_post[%0d]", i), 32'(out_valid), 32'd0);
        end

        // Stall in DONE with a competing frame offered; it must be ignored
        do_frame(4'd1, 4'd3, 4'd5, lat);
        chk("stall_lat", 32'(lat), 32'd1);
        @(negedge clk_arduino);
        in_valid = 1'b1; operador = 4'd0; operando_1 = 4'd1; operando_2 = 4'd1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_arduino);
            #1;
            chk($sformatf("stall_res[%0d]", k),   32'(resultado), 32'h0E);
            chk($sformatf("stall_flags[%0d]", k), 32'(flags),     32'b0110);
            chk($sformatf("stall_leds[%0d]", k),  32'(leds),      32'hF);
            chk($sformatf("stall_inrdy[%0d]", k), 32'(in_ready),  32'd0);
            chk($sformatf("stall_valid[%0d]", k), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        consume();
        chk("stall_leds_after", 32'(leds),     32'hE);
        chk("stall_inrdy_after", 32'(in_ready), 32'd1);

        // Reset during the second CALC cycle of MUL 7*6
        @(negedge clk_arduino);
        in_valid = 1'b1; operador = 4'd7; operando_1 = 4'd7; operando_2 = 4'd6;
        @(posedge clk_arduino);
        #1 in_valid = 1'b0;
        chk("mul_busy",   32'(busy),     32'd1);
        chk("mul_inrdy",  32'(in_ready), 32'd0);
        @(posedge clk_arduino);
        #1 reset = 1'b1;
        @(posedge clk_arduino);
        #1 reset = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_resultado", 32'(resultado), 32'd0);
        chk("abort_flags",     32'(flags),     32'd0);
        chk("abort_error",     32'(error),     32'd0);
        chk("abort_leds",      32'(leds),      32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        repeat (5) @(posedge clk_arduino);
        #1;
        chk("abort_no_result", 32'(out_valid), 32'd0);
        do_frame(4'd0, 4'd1, 4'd1, lat);
        chk("post_abort_lat", 32'(lat),       32'd1);
        chk("post_abort_res", 32'(resultado), 32'h02);
        chk("post_abort_err", 32'(error),     32'd0);
        consume();
        chk("post_abort_leds", 32'(leds), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
